adder_4_rr_seq: RTL and testbench

Nibble-serial wide-add sequencer that time-shares one 4-bit `adder_4` netlist (exact or any BLASYS approximation) between NREQ requesters. It arbitrates round-robin, feeds the operands to the adder one nibble per cycle with a registered carry, assembles the WIDTH-bit sum, and returns it on a valid/ready response port. It sits between client logic and the external `adder_4` instance, so approximate netlists can be swapped without touching the controller.

---
 rtl/adder_4_seq_pkg.sv | 10 +
 rtl/adder_4_rr_seq_arb.sv | 23 ++
 rtl/adder_4_rr_seq.sv | 86 ++++++++
 tb/tb_adder_4_rr_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_4_seq_pkg.sv
// adder_4_seq_pkg: sequencer FSM states, nibble width and adder_4 pin mapping (pi0..8 in, po0..4 out)
package adder_4_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  localparam int NIB_W = 4;
  localparam int PI_A0 = 0;
  localparam int PI_B0 = 4;
  localparam int PI_CIN = 8;
  localparam int PO_COUT = 0;
  localparam int PO_S0 = 4;
endpackage

// File: rtl/adder_4_rr_seq_arb.sv
// rr_arb: round-robin arbiter; valid/ptr in, one-hot grant and encoded idx out, first valid at or after ptr wins
module rr_arb
  import adder_4_seq_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic [NREQ-1:0] rot;
  int j;
  always_comb begin
    rot = NREQ'({valid, valid} >> ptr);
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) j = k;
    j = (j + int'(ptr)) % NREQ;
    idx = IDW'(j);
    grant = (|valid) ? NREQ'(1) << j : '0;
  end
endmodule

// File: rtl/adder_4_rr_seq.sv
// adder_4_rr_seq: round-robin nibble-serial WIDTH-bit adder over an external adder_4; req_*/rsp_* handshakes, add_* adder pins
module adder_4_rr_seq
  import adder_4_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_s,
  input  logic                  add_cout
);
  localparam int N = WIDTH / NIB_W;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [NW-1:0] LAST = NW'(N - 1);
  state_t state;
  logic [IDW-1:0] rr_ptr, id, gidx;
  logic [NREQ-1:0] grant;
  logic [NW-1:0] nib;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic carry;
  rr_arb #(.NREQ(NREQ)) u_arb (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gidx)
  );
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = state == RESP;
  assign rsp_sum = sum_r;
  assign rsp_cout = carry;
  assign rsp_id = id;
  assign add_a = (state == RUN) ? a_r[NIB_W-1:0] : '0;
  assign add_b = (state == RUN) ? b_r[NIB_W-1:0] : '0;
  assign add_cin = (state == RUN) & carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      nib <= '0;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          a_r <= WIDTH'(req_a >> (WIDTH * int'(gidx)));
          b_r <= WIDTH'(req_b >> (WIDTH * int'(gidx)));
          carry <= req_cin[gidx];
          id <= gidx;
          nib <= '0;
          state <= RUN;
        end
        RUN: begin
          a_r <= a_r >> NIB_W;
          b_r <= b_r >> NIB_W;
          sum_r <= (sum_r >> NIB_W) | (WIDTH'(add_s) << (WIDTH - NIB_W));
          carry <= add_cout;
          nib <= nib + NW'(1);
          if (nib == LAST) state <= RESP;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_4_rr_seq.sv
// tb_adder_4_rr_seq: directed checks of adder_4_rr_seq with an exact or stand-in approximate adder_4 attached
module tb_adder_4_rr_seq;
  import adder_4_seq_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_cin;
  logic [31:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_cout, add_cin, add_cout;
  logic [15:0] rsp_sum;
  logic [0:0] rsp_id;
  logic [3:0] add_a, add_b, add_s;
  logic [4:0] po;
  bit apx;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  adder_4_rr_seq #(.WIDTH(16), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );
  function automatic logic [4:0] netlist(input logic [8:0] pi, input bit ap);
    logic [3:0] a, b;
    logic [4:0] r, o;
    a = pi[PI_A0 +: 4];
    b = pi[PI_B0 +: 4];
    r = {1'b0, a} + {1'b0, b} + {4'b0, pi[PI_CIN]};
    if (ap) begin
      r = {1'b0, a} + {1'b0, b};
      r[0] = a[0] | b[0];
    end
    o[PO_COUT] = r[4];
    o[PO_S0] = r[0];
    o[PO_S0-1] = r[1];
    o[PO_S0-2] = r[2];
    o[PO_S0-3] = r[3];
    return o;
  endfunction
  function automatic logic [16:0] golden(input logic [15:0] a, b, input logic c, input bit ap);
    logic [15:0] s;
    logic [4:0] o;
    logic cy;
    cy = c;
    for (int n = 0; n < 4; n++) begin
      o = netlist({cy, b[4*n +: 4], a[4*n +: 4]}, ap);
      s[4*n +: 4] = {o[PO_S0-3], o[PO_S0-2], o[PO_S0-1], o[PO_S0]};
      cy = o[PO_COUT];
    end
    return {cy, s};
  endfunction
  always_comb begin
    po = netlist({add_cin, add_b, add_a}, apx);
    add_s = {po[PO_S0-3], po[PO_S0-2], po[PO_S0-1], po[PO_S0]};
    add_cout = po[PO_COUT];
  end
  task automatic set_req(input int r, input logic [15:0] a, b, input logic c);
    req_a[r*16 +: 16] = a;
    req_b[r*16 +: 16] = b;
    req_cin[r] = c;
    req_valid[r] = 1'b1;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask
  task automatic wait_rsp(output int k);
    k = 1;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    req_cin = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    apx = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, add_a, add_b, add_cin} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b id=%b rdy=%b a=%h b=%h ci=%b expected all 0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, add_a, add_b, add_cin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    int n, k;
    set_req(0, 16'h1234, 16'h4321, 1'b0);
    wait_ready(n);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(k);
    checks++;
    if (k !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", k); end
    checks++;
    if ({rsp_cout, rsp_sum, rsp_id} !== {1'b0, 16'h5555, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got c=%b s=%h id=%b expected c=0 s=5555 id=0", rsp_cout, rsp_sum, rsp_id);
    end
    @(negedge clk);
  endtask
  task automatic test_carry_ripple;
    int n;
    set_req(1, 16'hFFFF, 16'h0000, 1'b1);
    wait_ready(n);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL ripple_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({add_cin, add_a, add_b} !== {1'b1, 4'hF, 4'h0}) begin
        errors++;
        $display("FAIL ripple_run%0d: got ci=%b a=%h b=%h expected ci=1 a=f b=0", i, add_cin, add_a, add_b);
      end
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== {1'b1, 1'b1, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL ripple_result: got v=%b c=%b s=%h id=%b expected v=1 c=1 s=0000 id=1",
               rsp_valid, rsp_cout, rsp_sum, rsp_id);
    end
    @(negedge clk);
  endtask
  task automatic test_round_robin;
    int n, k;
    logic [0:0] ex;
    set_req(0, 16'h0001, 16'h0002, 1'b0);
    set_req(1, 16'h8000, 16'h8000, 1'b0);
    for (int t = 0; t < 4; t++) begin
      ex = 1'(t % 2);
      wait_ready(n);
      checks++;
      if (!$onehot(req_ready) || req_ready[ex] !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected grant to %0d", t, req_ready, ex);
      end
      @(negedge clk);
      wait_rsp(k);
      checks++;
      if ({rsp_id, rsp_cout, rsp_sum} !== (ex ? {1'b1, 1'b1, 16'h0000} : {1'b0, 1'b0, 16'h0003})) begin
        errors++;
        $display("FAIL rr_result%0d: got id=%b c=%b s=%h expected id=%b", t, rsp_id, rsp_cout, rsp_sum, ex);
      end
      if (t == 3) req_valid = '0;
      @(negedge clk);
    end
  endtask
  task automatic test_backpressure;
    int n, k;
    rsp_ready = 1'b0;
    set_req(0, 16'hABCD, 16'h1111, 1'b0);
    set_req(1, 16'h0F0F, 16'h0101, 1'b0);
    wait_ready(n);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(k);
    checks++;
    if (k !== 5) begin errors++; $display("FAIL bp_latency: got %0d expected 5", k); end
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_cout, rsp_sum, rsp_id, req_ready} !== {1'b1, 1'b0, 16'hBCDE, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b c=%b s=%h id=%b rdy=%b expected v=1 c=0 s=bcde id=0 rdy=00",
                 i, rsp_valid, rsp_cout, rsp_sum, rsp_id, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(k);
    checks++;
    if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b0, 16'h1010}) begin
      errors++;
      $display("FAIL bp_second: got id=%b c=%b s=%h expected id=1 c=0 s=1010", rsp_id, rsp_cout, rsp_sum);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int n, k;
    bit seen;
    set_req(0, 16'h0FFF, 16'h0001, 1'b0);
    wait_ready(n);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({add_a, add_b, add_cin} !== {4'hF, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_nib2: got a=%h b=%h ci=%b expected a=f b=0 ci=1", add_a, add_b, add_cin);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, add_a, add_b, add_cin} !== 30'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b s=%h c=%b id=%b rdy=%b a=%h b=%h ci=%b expected all 0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, add_a, add_b, add_cin);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_valid seen=%b expected 0", seen); end
    set_req(0, 16'h0FFF, 16'h0001, 1'b0);
    set_req(1, 16'h0003, 16'h0004, 1'b0);
    wait_ready(n);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_regrant: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(k);
    checks++;
    if ({rsp_id, rsp_cout, rsp_sum} !== {1'b0, 1'b0, 16'h1000}) begin
      errors++;
      $display("FAIL rstmid_result: got id=%b c=%b s=%h expected id=0 c=0 s=1000", rsp_id, rsp_cout, rsp_sum);
    end
    @(negedge clk);
  endtask
  task automatic test_approx;
    int n, k, r;
    logic [15:0] a, b;
    logic c;
    logic [16:0] ex;
    apx = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 1);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      ex = golden(a, b, c, 1'b1);
      set_req(r, a, b, c);
      wait_ready(n);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(k);
      checks++;
      if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'(r), ex}) begin
        errors++;
        $display("FAIL approx%0d: got v=%b id=%b c=%b s=%h expected v=1 id=%0d c=%b s=%h (a=%h b=%h cin=%b)",
                 i, rsp_valid, rsp_id, rsp_cout, rsp_sum, r, ex[16], ex[15:0], a, b, c);
      end
      @(negedge clk);
    end
    apx = 1'b0;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_carry_ripple;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_approx;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
